// File: rtl/tc4_calc_pkg.sv
// tc4_calc_pkg: shared types, widths and op encodings for the 4-bit calculator.
package tc4_calc_pkg;

    localparam int W = 4;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_RES = 2'b10
    } tc4_state_e;

    // Returns {overflow, result}; b is the already-inverted operand for subtract.
    function automatic logic [W:0] add_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W-1:0] r;
        r = a + b + W'(cin);
        return {(a[W-1] == b[W-1]) && (r[W-1] != a[W-1]), r};
    endfunction

endpackage

// File: rtl/tc4_debounce.sv
// tc4_debounce: synchronizes and debounces an active-low button, emitting one press pulse per accepted press.
module tc4_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1_q, s2_q;
    logic [1:0]    vld_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, prev_q;
    logic          armed_q, armed_d;
    logic          differ, done;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            vld_q   <= '0;
            cnt_q   <= '0;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= btn_n_i;
            s2_q    <= s1_q;
            vld_q   <= {vld_q[0], 1'b1};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            armed_q <= armed_d;
        end
    end

    // Presses are only honoured once the button has been seen released after reset.
    always_comb begin
        differ  = s2_q != level_q;
        done    = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d   = (differ && !done) ? cnt_q + 1'b1 : '0;
        level_d = done ? s2_q : level_q;
        armed_d = armed_q | (vld_q[1] & s2_q & level_q);
        press_o = armed_q & prev_q & ~level_q;
    end

endmodule

// File: rtl/tc4_calc.sv
// tc4_calc: two-operand 4-bit two's complement add/subtract calculator driven by one debounced button.
module tc4_calc
    import tc4_calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic [W-1:0] Din,
    input  logic         Op,
    input  logic         Enter,
    output logic [W-1:0] N,
    output logic         Overflow,
    output logic [1:0]   Phase
);

    tc4_state_e   state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic         ovf_q, ovf_d;
    logic         press;
    logic [W:0]   res;

    tc4_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .Clock  (Clock),
        .Resetn (Resetn),
        .btn_n_i(Enter),
        .press_o(press)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        res     = add_ovf(a_q, (Op == OP_SUB) ? ~Din : Din, Op == OP_SUB);
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_A: if (press) begin
                a_d     = Din;
                state_d = S_B;
            end
            S_B: if (press) begin
                b_d     = Din;
                r_d     = res[W-1:0];
                ovf_d   = res[W];
                state_d = S_RES;
            end
            S_RES: if (press) begin
                ovf_d   = 1'b0;
                state_d = S_A;
            end
            default: state_d = S_A;
        endcase
    end

    assign N        = (state_q == S_RES) ? r_q : Din;
    assign Overflow = ovf_q;
    assign Phase    = state_q;

endmodule

// File: doc/tc4_calc.md
TC4_CALC -- requirements
Module: tc4_calc

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a button level (10 ms at 50 MHz).
REQ-002 Clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 Din  input  4  operand entry from slide switches, 4-bit two's complement.
REQ-005 Op  input  1  operation select: 0 = add, 1 = subtract (A - B).
REQ-006 Enter  input  1  raw push-button, active-low (0 = pressed), asynchronous to Clock.
REQ-007 N  output  4  4-bit two's complement value presented to the sign/magnitude 7-segment stage.
REQ-008 Overflow  output  1  signed overflow of the last computed result.
REQ-009 Phase  output  2  current state: 00 = entering A, 01 = entering B, 10 = showing result.

Function
REQ-010 Enter SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 The debouncer SHALL change its accepted level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any shorter excursion restarts the count.
REQ-012 A press event SHALL be a single-cycle pulse on the accepted level's 1-to-0 transition; a held button SHALL yield exactly one pulse, and release SHALL yield none.
REQ-013 The FSM SHALL have states S_A, S_B and S_RES, encoded 00, 01 and 10 and driven directly on Phase; encoding 11 SHALL recover to S_A on the next edge.
REQ-014 In S_A, a press pulse SHALL capture Din into register A and move to S_B.
REQ-015 In S_B, a press pulse SHALL capture Din into B, compute R from A, the current Din and Op sampled in that same cycle, register R and Overflow, and move to S_RES.
REQ-016 In S_RES, a press pulse SHALL move to S_A; A, B, R and Overflow SHALL hold until overwritten.
REQ-017 N SHALL equal Din combinationally in S_A and S_B, and registered R in S_RES; Din and Op changes in S_RES SHALL NOT affect N or Overflow.
REQ-018 R SHALL be the sum or difference truncated to 4 bits (modulo 16); subtract SHALL be A + ~B + 1.
REQ-019 Overflow SHALL be 1 when both operands of the effective addition share a sign that differs from R's sign, and 0 otherwise.
REQ-020 Overflow SHALL be cleared on the transition from S_RES to S_A.
REQ-021 Latency: the state, R and Overflow SHALL update on the edge following the press pulse.

Reset
REQ-022 Asserting Resetn low SHALL immediately force S_A, clear A, B and R to 0, clear Overflow to 0, zero the debounce counter, and set the synchronizer flops and accepted level to 1 (released).
REQ-023 Reset asserted mid-operation, in any state or with the button held, SHALL abandon the operation; after release, a still-held button SHALL NOT generate a press until it has been released and pressed again.
REQ-024 After release, the outputs SHALL be N = Din, Overflow = 0 and Phase = 00.

Structure
REQ-025 A shared package tc4_calc_pkg SHALL hold the state enum (S_A, S_B, S_RES), the data width constant (4) and the Op encodings.
REQ-026 The synchronizer, debouncer and press-pulse logic SHALL be a single sub-module, tc4_debounce, parameterized by DEBOUNCE_CYCLES.
REQ-027 The FSM, operand registers and adder/overflow logic SHALL live in tc4_calc.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 Press with Din = 0011, then press with Din = 0100 and Op = 0 -> Phase goes 00, 01, 10; N = 0111; Overflow = 0.
REQ-029 A = 0111, B = 0001, Op = 0 -> N = 1000 (-8), Overflow = 1; A = 1000, B = 0001, Op = 1 -> N = 0111, Overflow = 1.
REQ-030 A = 1000, B = 1000, Op = 1 -> N = 0000, Overflow = 0; A = 0000, B = 1000, Op = 1 -> N = 1000, Overflow = 1.
REQ-031 Enter bounces low for 3 cycles then is held low for 20 cycles -> exactly one press pulse, one Phase step; bounce alone -> no step.
REQ-032 In S_RES, toggle Din and Op -> N and Overflow unchanged; press -> Phase = 00, Overflow = 0, N follows Din.
REQ-033 Assert Resetn in S_B while Enter is held -> Phase = 00 immediately; no further step until Enter is released and pressed again.
